// File: rtl/crop_stream_framer.sv
// crop_stream_framer: FWFT FIFO + valid/ready output stage for the cropped
// pixel stream, tagging each output pixel with SOF/EOL/EOF from the cropped
// frame geometry. The upstream never stalls, so a full FIFO drops the input
// pixel and latches the sticky overflow flag.
// Optional feature macro: CROP_FRAMER_DROP_COUNT_EN adds a saturating
// 16-bit drop_count output.
module crop_stream_framer #(
    parameter int PIX_W    = 12,
    parameter int OUT_ROWS = 20,
    parameter int OUT_COLS = 20,
    parameter int DEPTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] pixel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
`ifdef CROP_FRAMER_DROP_COUNT_EN
    output logic             overflow,
    output logic [15:0]      drop_count
`else
    output logic             overflow
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int RW    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CNT_W-1:0] count;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             fresh;   // set by reset, cleared by first push: lets SOF show while idle after reset
    logic             push, pop, drop;
    logic             at_eol, at_last_row, at_sof;

    // Handshake and status decode, all from registered state
    assign in_ready    = (count != CNT_W'(DEPTH));
    assign out_valid   = (count != '0);
    assign push        = in_valid && in_ready;
    assign drop        = in_valid && !in_ready;
    assign pop         = out_valid && out_ready;
    assign pixel_out   = mem[rptr];

    assign at_eol      = (col == CW'(OUT_COLS - 1));
    assign at_last_row = (row == RW'(OUT_ROWS - 1));
    assign at_sof      = (row == '0) && (col == '0);

    assign out_sof     = at_sof && (out_valid || fresh);
    assign out_eol     = at_eol && out_valid;
    assign out_eof     = at_eol && at_last_row && out_valid;

    // Pixel storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pixel_in;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            fresh    <= 1'b1;
        end else begin
            if (push) begin
                wptr  <= wptr + 1'b1;
                fresh <= 1'b0;
            end
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Framing position advances only when a pixel leaves
    always_ff @(posedge clk) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (at_eol) begin
                col <= '0;
                row <= at_last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef CROP_FRAMER_DROP_COUNT_EN
    // Saturating count of dropped pixels
    always_ff @(posedge clk) begin
        if (!reset)                            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_crop_stream_framer.sv
// Self-checking bench for crop_stream_framer (2x3 frame, DEPTH 4).
module tb_crop_stream_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pixel_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof, out_eol, out_eof;
    logic        overflow;
`ifdef CROP_FRAMER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    crop_stream_framer #(.PIX_W(12), .OUT_ROWS(2), .OUT_COLS(3), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(in_ready), .pixel_out(pixel_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof),
`ifdef CROP_FRAMER_DROP_COUNT_EN
        .overflow(overflow), .drop_count(drop_count)
`else
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [11:0] pin;
        logic        ordy;
        logic        v;
        logic [11:0] pix;
        logic        sof, eol, eof;
        logic        ir, ovf;
        logic        chkfl;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic iv, logic [11:0] pin, logic ordy,
                                logic v, logic [11:0] pix, logic sof, logic eol,
                                logic eof, logic ir, logic ovf, logic chkfl);
        vec_t t;
        t.rst = rst; t.iv = iv; t.pin = pin; t.ordy = ordy; t.v = v; t.pix = pix;
        t.sof = sof; t.eol = eol; t.eof = eof; t.ir = ir; t.ovf = ovf; t.chkfl = chkfl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [11:0] pin, input logic ordy);
        reset = ~rst; in_valid = iv; pixel_in = pin; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] q[$];
        int mcol, mrow, npush, npop, nexp;
        logic iv, ordy;

        reset = 1'b0; in_valid = 1'b0; pixel_in = '0; out_ready = 1'b0;

        // rst iv pin ordy | v pix sof eol eof ir ovf chkfl  (expected after the edge)
        vt.push_back(mk(1,0,12'h000,1, 0,12'h000,1,0,0,1,0,1));
        vt.push_back(mk(1,0,12'h000,1, 0,12'h000,1,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h001,1, 1,12'h001,1,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h002,1, 1,12'h002,0,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h003,1, 1,12'h003,0,1,0,1,0,1));
        vt.push_back(mk(0,1,12'h004,1, 1,12'h004,0,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h005,1, 1,12'h005,0,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h006,1, 1,12'h006,0,1,1,1,0,1));
        vt.push_back(mk(0,0,12'h000,1, 0,12'h000,0,0,0,1,0,0));
        // backpressure: fill, then drop, head holds stable
        vt.push_back(mk(0,1,12'h0A0,0, 1,12'h0A0,1,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h0A1,0, 1,12'h0A0,1,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h0A2,0, 1,12'h0A0,1,0,0,1,0,1));
        vt.push_back(mk(0,1,12'h0A3,0, 1,12'h0A0,1,0,0,0,0,1));
        vt.push_back(mk(0,1,12'h0A4,0, 1,12'h0A0,1,0,0,0,1,1));
        // full with simultaneous pop: head leaves, input dropped, count 3
        vt.push_back(mk(0,1,12'h0A5,1, 1,12'h0A1,0,0,0,1,1,1));
        vt.push_back(mk(0,0,12'h000,1, 1,12'h0A2,0,1,0,1,1,1));
        vt.push_back(mk(0,0,12'h000,1, 1,12'h0A3,0,0,0,1,1,1));
        vt.push_back(mk(0,0,12'h000,1, 0,12'h000,0,0,0,1,1,0));

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].iv, vt[i].pin, vt[i].ordy);
            chk($sformatf("v%0d_valid", i), out_valid, vt[i].v);
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].ir);
            chk($sformatf("v%0d_overflow", i), overflow, vt[i].ovf);
            if (vt[i].v) chk($sformatf("v%0d_pixel", i), pixel_out, vt[i].pix);
            if (vt[i].chkfl) begin
                chk($sformatf("v%0d_sof", i), out_sof, vt[i].sof);
                chk($sformatf("v%0d_eol", i), out_eol, vt[i].eol);
                chk($sformatf("v%0d_eof", i), out_eof, vt[i].eof);
            end
        end

        // Wrap-around: 10 pixels, alternating out_ready, never full
        step(1, 0, 12'h000, 0);
        mcol = 0; mrow = 0; npush = 0; npop = 0;
        for (int c = 0; c < 80; c++) begin
            iv   = (npush < 10) && (q.size() < 3);
            ordy = c[0];
            reset = 1'b1; in_valid = iv; pixel_in = 12'h200 + 12'(npush); out_ready = ordy;
            @(posedge clk);
            if (q.size() != 0 && ordy) begin
                void'(q.pop_front());
                npop++;
                if (mcol == 2) begin mcol = 0; mrow = (mrow == 1) ? 0 : 1; end
                else mcol++;
            end
            if (iv) begin q.push_back(12'h200 + 12'(npush)); npush++; end
            #1;
            chk("wrap_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("wrap_pixel", pixel_out, q[0]);
                chk("wrap_sof", out_sof, (mrow == 0 && mcol == 0));
                chk("wrap_eol", out_eol, (mcol == 2));
                chk("wrap_eof", out_eof, (mcol == 2 && mrow == 1));
            end
            if (npush == 10 && q.size() == 0) break;
        end
        nexp = 10;
        chk("wrap_popped", npop, nexp);

        // Reset mid-frame discards buffered pixels
        step(0, 1, 12'h301, 0);
        step(0, 1, 12'h302, 0);
        step(0, 1, 12'h303, 0);
        chk("midrst_pre_valid", out_valid, 1'b1);
        step(1, 0, 12'h000, 0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sof", out_sof, 1'b1);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_overflow", overflow, 1'b0);
        step(0, 1, 12'h100, 0);
        chk("midrst_first_valid", out_valid, 1'b1);
        chk("midrst_first_pixel", pixel_out, 12'h100);
        chk("midrst_first_sof", out_sof, 1'b1);
        chk("midrst_first_overflow", overflow, 1'b0);
        step(0, 0, 12'h000, 0);
        chk("midrst_hold_pixel", pixel_out, 12'h100);

`ifdef CROP_FRAMER_DROP_COUNT_EN
        step(1, 0, 12'h000, 0);
        chk("dc_reset", drop_count, 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h400 + 12'(i), 0);
        chk("dc_full_zero", drop_count, 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 1, 12'h4F0, 0);
        chk("dc_five", drop_count, 16'd5);
        chk("dc_overflow", overflow, 1'b1);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("dc_saturate", drop_count, 16'hFFFF);
        chk("dc_head_kept", pixel_out, 12'h400);
`endif

        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crop_stream_framer.md
Name: crop_stream_framer

Overview:
- Downstream stage of the crop filter. Absorbs the cropped 12-bit pixel stream in a first-word-fall-through FIFO.
- Re-emits the stream with a true valid/ready handshake, so the sink may stall without losing pixels. The crop filter itself cannot stall.
- Tags each output pixel with start-of-frame, end-of-line and end-of-frame markers derived from the cropped frame geometry.
- Sits between the crop filter output and the pixel consumer (display or DMA writer).

Parameters:
- PIX_W, 12, pixel width in bits.
- OUT_ROWS, 20, rows per cropped frame.
- OUT_COLS, 20, columns per cropped frame.
- DEPTH, 16, FIFO depth in pixels; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- pixel_in  input  PIX_W  pixel from the crop filter.
- in_valid  input  1  pixel_in valid this cycle.
- in_ready  output  1  FIFO can accept; advisory only, because the upstream does not stall.
- pixel_out  output  PIX_W  head-of-FIFO pixel.
- out_valid  output  1  pixel_out valid.
- out_ready  input  1  sink accepts pixel_out this cycle.
- out_sof  output  1  pixel_out is row 0, col 0 of a frame.
- out_eol  output  1  pixel_out is the last column of its row.
- out_eof  output  1  pixel_out is the last pixel of the frame.
- overflow  output  1  sticky; a pixel was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Clears read pointer, write pointer, count, row/col counters and overflow.
  - Outputs after reset: out_valid=0, in_ready=1, overflow=0, out_sof=1 (counters at 0,0), out_eol=0, out_eof=0. The pixel_out value is don't-care while out_valid=0.
  - Reset mid-frame discards all buffered pixels, and the next accepted pixel is treated as frame start.
- Push: when in_valid && count<DEPTH, the pixel is written at wptr and wptr increments modulo DEPTH.
- Pop: when out_valid && out_ready, rptr increments modulo DEPTH.
- Count:
  - Width is $clog2(DEPTH)+1.
  - Increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- in_ready = (count<DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- Full with simultaneous pop: in_valid is still dropped, because the push decision uses pre-edge count.
- Drop: when in_valid && count==DEPTH, the pixel is discarded, overflow is set to 1, and overflow holds until reset.
- out_valid = (count!=0). pixel_out = mem[rptr], fall-through.
- Latency: a pixel pushed at edge N is presented with out_valid=1 in the cycle after edge N, when the FIFO was empty. Minimum latency is 1 cycle.
- Output stability: while out_valid && !out_ready, pixel_out and all flags hold stable.
- Framing counters col (0..OUT_COLS-1) and row (0..OUT_ROWS-1) advance only on a pop:
  - col increments. At OUT_COLS-1, col wraps to 0 and row increments.
  - At row OUT_ROWS-1 with col OUT_COLS-1, both wrap to 0.
- Framing flags:
  - out_sof = (row==0 && col==0).
  - out_eol = (col==OUT_COLS-1).
  - out_eof = out_eol && (row==OUT_ROWS-1).
  - All three are gated with out_valid, except out_sof, which is also asserted at reset as stated above.
- Dropped pixels do not advance the framing counters. Framing therefore slips after an overflow, and overflow flags this condition for software.
- Pointer wrap at DEPTH-1 to 0 must be seamless, with no bubble.

Optional Feature:
- Macro: CROP_FRAMER_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count [15:0].
  - drop_count increments once per dropped pixel and saturates at 16'hFFFF.
  - drop_count is cleared by reset.
  - overflow behaviour is unchanged.
- When undefined: the port and counter are absent, and only the sticky overflow exists.

Test Plan:
1. Reset then stream; OUT_ROWS=2, OUT_COLS=3, DEPTH=4, out_ready=1.
   - Stimulus: reset low 2 cycles, then in_valid=1 with pixels 0x001..0x006 on consecutive cycles.
   - Required: each pixel appears one cycle later in order. out_sof is set on 0x001, out_eol on 0x003 and 0x006, out_eof on 0x006 only. overflow=0.
2. Backpressure; out_ready=0.
   - Stimulus: push 0x0A0..0x0A3. Then push 0x0A4 while count==4.
   - Required: in_ready=0 after the 4th push, 0x0A4 is dropped, overflow=1. With out_ready=1 afterwards, output is 0x0A0..0x0A3 only.
3. Full with simultaneous pop.
   - Stimulus: count==4, in_valid=1, out_ready=1 in the same cycle.
   - Required: the head pops, the input is dropped, count=3, overflow=1.
4. Wrap-around.
   - Stimulus: 10 pixels with alternating out_ready on a DEPTH=4 FIFO, never filling.
   - Required: output order is identical to input order, and there is no data loss across pointer wrap.
5. Reset mid-frame.
   - Stimulus: after 3 of 6 pixels are buffered, assert reset low 1 cycle, then send 0x100.
   - Required: out_valid=0 after reset. 0x100 is emitted with out_sof=1, and overflow=0.
6. With CROP_FRAMER_DROP_COUNT_EN defined.
   - Stimulus: drive 5 pixels into a full FIFO.
   - Required: drop_count=5. After forcing 70000 drops, drop_count=16'hFFFF.
